// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: issues one fetch at a time to the memory arbiter,
// forwards returned blocks to the ibuffer and handles redirects. Optional macro: IFU_FETCH_PERF_CNT_EN.
module ifu_fetch_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int unsigned FETCH_BYTES = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_inst,
  input  logic        i_fifo_empty,
  input  logic        i_mem_stall,
  input  logic        i_redirect_valid,
  input  logic [63:0] i_redirect_target,
  output logic        o_pc_index_valid,
  output logic [63:0] o_pc_index,
  input  logic        i_pc_index_ready,
  input  logic        i_pc_operation_done,
  output logic        o_ibuf_operation_done,
  output logic [63:0] o_ibuf_pc,
  output logic        o_clear_ibuffer,
  output logic        o_can_fetch_inst
`ifdef IFU_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_redirect_cnt
`endif
);

  localparam logic [63:0] LP_PC_INC = 64'(FETCH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_fetch_pc;
  logic [63:0] w_fetch_pc_next;
  logic        w_fetch_done;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        if (!i_redirect_valid && (i_fetch_inst || i_fifo_empty) && !i_mem_stall)
          w_state_next = S_REQ;
      end
      S_REQ: begin
        // An accepted request whose data is now stale must still be drained.
        if (i_redirect_valid)
          w_state_next = i_pc_index_ready ? S_DISCARD : S_IDLE;
        else if (i_pc_index_ready)
          w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_pc_operation_done) begin
          w_state_next = S_IDLE;
          if (!i_redirect_valid)
            w_fetch_pc_next = r_fetch_pc + LP_PC_INC;
        end else if (i_redirect_valid) begin
          w_state_next = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (i_pc_operation_done)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (i_redirect_valid)
      w_fetch_pc_next = i_redirect_target;
  end

  always_comb begin
    w_fetch_done          = (r_state == S_WAIT) && i_pc_operation_done
                            && !i_redirect_valid && !i_reset;
    o_pc_index_valid      = (r_state == S_REQ) && !i_reset;
    o_pc_index            = r_fetch_pc;
    o_ibuf_operation_done = w_fetch_done;
    o_ibuf_pc             = r_fetch_pc;
    o_clear_ibuffer       = i_redirect_valid;
    o_can_fetch_inst      = (r_state == S_IDLE) && !i_redirect_valid;
  end

`ifdef IFU_FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_redirect_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_perf_fetch_cnt    <= 32'd0;
      r_perf_redirect_cnt <= 32'd0;
    end else begin
      if (w_fetch_done)
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (i_redirect_valid)
        r_perf_redirect_cnt <= r_perf_redirect_cnt + 32'd1;
    end
  end

  assign o_perf_fetch_cnt    = r_perf_fetch_cnt;
  assign o_perf_redirect_cnt = r_perf_redirect_cnt;
`endif

endmodule
